// File: rtl/tlk2711_rx_ring_ctrl.sv
// rtl/tlk2711_rx_ring_ctrl.sv - RX buffer ring sequencer for the TLK2711 link
module tlk2711_rx_ring_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BUF    = 4,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_soft_rst,
    input  logic                  i_enable,
    input  logic [ADDR_WIDTH-1:0] i_ring_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_buf_stride,
    input  logic                  i_rx_interrupt,
    input  logic [31:0]           i_rx_total_packet,
    input  logic                  i_host_release,
    output logic                  o_rx_start,
    output logic [ADDR_WIDTH-1:0] o_rx_base_addr,
    output logic                  o_buf_done,
    output logic [IDX_WIDTH-1:0]  o_done_idx,
    output logic [31:0]           o_done_len,
    output logic [IDX_WIDTH-1:0]  o_wr_idx,
    output logic [IDX_WIDTH-1:0]  o_rd_idx,
    output logic [IDX_WIDTH:0]    o_occupancy,
    output logic                  o_overflow,
    output logic [15:0]           o_drop_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_PKT,
        ST_COMMIT,
        ST_STALL
    } state_t;

    localparam logic [IDX_WIDTH:0]    OCC_FULL    = (IDX_WIDTH+1)'(NUM_BUF);
    localparam logic [IDX_WIDTH:0]    OCC_ONE     = (IDX_WIDTH+1)'(1);
    localparam logic [IDX_WIDTH-1:0]  IDX_ONE     = IDX_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_MASK = ~ADDR_WIDTH'(7);

    state_t                state;
    state_t                state_nxt;
    logic                  irq_q;
    logic                  edge_q;
    logic                  reload_q;
    logic [ADDR_WIDTH-1:0] addr_acc;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] stride_masked;
    logic [IDX_WIDTH:0]    occ_nxt;
    logic                  commit;
    logic                  release_ok;
    logic                  drop;

    assign stride_masked = i_buf_stride & STRIDE_MASK;
    assign commit        = (state == ST_COMMIT);
    assign release_ok    = i_host_release && (o_occupancy != '0);
    // Any edge outside WAIT_PKT has no armed buffer to land in.
    assign drop          = edge_q && (state != ST_WAIT_PKT);

    assign o_rx_start     = (state == ST_START);
    assign o_buf_done     = commit;
    assign o_rx_base_addr = reload_q ? i_ring_base_addr : addr_acc;

    always_comb begin
        occ_nxt = o_occupancy;
        if (commit && !release_ok) begin
            occ_nxt = o_occupancy + OCC_ONE;
        end else if (!commit && release_ok) begin
            occ_nxt = o_occupancy - OCC_ONE;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_enable) begin
                    state_nxt = (o_occupancy == OCC_FULL) ? ST_STALL : ST_START;
                end
            end
            ST_START: state_nxt = ST_WAIT_PKT;
            ST_WAIT_PKT: begin
                if (edge_q) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (!i_enable) begin
                    state_nxt = ST_IDLE;
                end else if (occ_nxt == OCC_FULL) begin
                    state_nxt = ST_STALL;
                end else begin
                    state_nxt = ST_START;
                end
            end
            ST_STALL: begin
                if (!i_enable) begin
                    state_nxt = ST_IDLE;
                end else if (o_occupancy != OCC_FULL) begin
                    state_nxt = ST_START;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            irq_q       <= 1'b0;
            edge_q      <= 1'b0;
            reload_q    <= 1'b1;
            o_wr_idx    <= '0;
            o_rd_idx    <= '0;
            o_occupancy <= '0;
            o_done_idx  <= '0;
            o_done_len  <= '0;
            o_overflow  <= 1'b0;
            o_drop_cnt  <= '0;
        end else if (i_soft_rst) begin
            state       <= ST_IDLE;
            irq_q       <= 1'b0;
            edge_q      <= 1'b0;
            reload_q    <= 1'b1;
            o_wr_idx    <= '0;
            o_rd_idx    <= '0;
            o_occupancy <= '0;
            o_done_idx  <= '0;
            o_done_len  <= '0;
            o_overflow  <= 1'b0;
            o_drop_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            irq_q       <= i_rx_interrupt;
            edge_q      <= i_rx_interrupt & ~irq_q;
            o_occupancy <= occ_nxt;
            if (state == ST_START) begin
                reload_q <= 1'b0;
            end
            if (commit) begin
                o_done_idx <= o_wr_idx;
                o_done_len <= i_rx_total_packet;
                o_wr_idx   <= o_wr_idx + IDX_ONE;
            end
            if (release_ok) begin
                o_rd_idx <= o_rd_idx + IDX_ONE;
            end
            if (drop) begin
                o_overflow <= 1'b1;
                if (o_drop_cnt != 16'hFFFF) begin
                    o_drop_cnt <= o_drop_cnt + 16'd1;
                end
            end
        end
    end

    // While reload_q is set the output follows the live base, so base and
    // stride are sampled every cycle until the first buffer is armed.
    always_ff @(posedge clk) begin
        if (reload_q) begin
            addr_acc <= i_ring_base_addr;
            stride_q <= stride_masked;
        end else if (commit) begin
            if (o_wr_idx == '1) begin
                addr_acc <= i_ring_base_addr;
                stride_q <= stride_masked;
            end else begin
                addr_acc <= addr_acc + stride_q;
            end
        end
    end

endmodule

// File: tb/tb_tlk2711_rx_ring_ctrl.sv
// tb/tb_tlk2711_rx_ring_ctrl.sv - scoreboard bench for tlk2711_rx_ring_ctrl
module tb_tlk2711_rx_ring_ctrl;

    localparam int AW = 32;
    localparam int NB = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_soft_rst;
    logic          i_enable;
    logic [AW-1:0] i_ring_base_addr;
    logic [AW-1:0] i_buf_stride;
    logic          i_rx_interrupt;
    logic [31:0]   i_rx_total_packet;
    logic          i_host_release;
    logic          o_rx_start;
    logic [AW-1:0] o_rx_base_addr;
    logic          o_buf_done;
    logic [IW-1:0] o_done_idx;
    logic [31:0]   o_done_len;
    logic [IW-1:0] o_wr_idx;
    logic [IW-1:0] o_rd_idx;
    logic [IW:0]   o_occupancy;
    logic          o_overflow;
    logic [15:0]   o_drop_cnt;

    always #5 clk = ~clk;

    tlk2711_rx_ring_ctrl #(.ADDR_WIDTH(AW), .NUM_BUF(NB), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .i_soft_rst(i_soft_rst), .i_enable(i_enable),
        .i_ring_base_addr(i_ring_base_addr), .i_buf_stride(i_buf_stride),
        .i_rx_interrupt(i_rx_interrupt), .i_rx_total_packet(i_rx_total_packet),
        .i_host_release(i_host_release), .o_rx_start(o_rx_start),
        .o_rx_base_addr(o_rx_base_addr), .o_buf_done(o_buf_done),
        .o_done_idx(o_done_idx), .o_done_len(o_done_len), .o_wr_idx(o_wr_idx),
        .o_rd_idx(o_rd_idx), .o_occupancy(o_occupancy), .o_overflow(o_overflow),
        .o_drop_cnt(o_drop_cnt)
    );

    typedef struct { logic [31:0] addr; int cyc; } start_t;
    typedef struct { int idx; logic [31:0] len; int cyc; } done_t;

    start_t      start_q[$];
    done_t       done_q[$];
    start_t      s_item;
    done_t       d_item;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_wr, m_rd, m_occ, m_drop;
    bit          m_ovf;
    logic [31:0] m_base, m_stride;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reload();
        m_base   = i_ring_base_addr;
        m_stride = i_buf_stride & 32'hFFFF_FFF8;
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_occ = 0; m_drop = 0; m_ovf = 0;
        model_reload();
    endtask

    task automatic push_start(input int c);
        start_t t;
        t.addr = m_base + 32'(m_wr) * m_stride;
        t.cyc  = c;
        start_q.push_back(t);
    endtask

    task automatic enable_ring();
        i_enable = 1'b1;
        model_reload();
        if (m_occ < NB) push_start(-1);
        repeat (4) @(posedge clk);
    endtask

    task automatic send_pkt(input logic [31:0] len, input int hold, input bit with_rel);
        int    t0;
        int    h;
        done_t d;
        h = (with_rel && hold < 3) ? 3 : hold;
        @(posedge clk); #1;
        i_rx_interrupt    = 1'b1;
        i_rx_total_packet = len;
        t0 = cyc;
        if (m_occ < NB) begin
            if (with_rel && m_occ > 0) begin
                m_rd  = (m_rd + 1) % NB;
                m_occ = m_occ - 1;
            end
            d.idx = m_wr; d.len = len; d.cyc = t0 + 2;
            done_q.push_back(d);
            m_wr  = (m_wr + 1) % NB;
            m_occ = m_occ + 1;
            if (m_wr == 0) model_reload();
            if (m_occ < NB) push_start(t0 + 3);
        end else begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop = m_drop + 1;
        end
        for (int k = 0; k < h; k++) begin
            @(posedge clk); #1;
            i_host_release = (with_rel && k == 1);
        end
        i_host_release = 1'b0;
        i_rx_interrupt = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic do_release();
        bit was_full;
        @(posedge clk); #1;
        i_host_release = 1'b1;
        if (m_occ > 0) begin
            was_full = (m_occ == NB);
            m_rd  = (m_rd + 1) % NB;
            m_occ = m_occ - 1;
            if (was_full) push_start(-1);
        end
        @(posedge clk); #1;
        i_host_release = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_occupancy"}, o_occupancy, m_occ);
        check({tag, "_wr_idx"}, o_wr_idx, m_wr);
        check({tag, "_rd_idx"}, o_rd_idx, m_rd);
        check({tag, "_overflow"}, o_overflow, m_ovf);
        check({tag, "_drop_cnt"}, o_drop_cnt, m_drop);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_start"}, o_rx_start, 0);
        check({tag, "_buf_done"}, o_buf_done, 0);
        check({tag, "_done_idx"}, o_done_idx, 0);
        check({tag, "_done_len"}, o_done_len, 0);
        check({tag, "_wr_idx"}, o_wr_idx, 0);
        check({tag, "_rd_idx"}, o_rd_idx, 0);
        check({tag, "_occupancy"}, o_occupancy, 0);
        check({tag, "_overflow"}, o_overflow, 0);
        check({tag, "_drop_cnt"}, o_drop_cnt, 0);
        check({tag, "_base_addr"}, o_rx_base_addr, 32'h1000_0000);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_rx_start) begin
                if (start_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_start_unexpected: actual pulse addr 0x%0h required no pulse", o_rx_base_addr);
                end else begin
                    s_item = start_q.pop_front();
                    check("rx_start_addr", o_rx_base_addr, s_item.addr);
                    if (s_item.cyc >= 0) check("rx_start_latency", cyc, s_item.cyc);
                end
            end
            if (o_buf_done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL buf_done_unexpected: actual pulse idx %0d required no pulse", o_done_idx);
                end else begin
                    d_item = done_q.pop_front();
                    check("done_latency", cyc, d_item.cyc);
                    @(posedge clk); #1;
                    check("done_idx", o_done_idx, d_item.idx);
                    check("done_len", o_done_len, d_item.len);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual no finish required finish within time limit");
        $fatal(1);
    end

    initial begin
        int op;
        rst_n = 1'b0; i_soft_rst = 1'b0; i_enable = 1'b0;
        i_ring_base_addr = 32'h1000_0000; i_buf_stride = 32'h0000_4000;
        i_rx_interrupt = 1'b0; i_rx_total_packet = '0; i_host_release = 1'b0;
        model_reset();
        #12;
        check_reset_vals("por");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        enable_ring();

        send_pkt(32'h800, 10, 1'b0);
        send_pkt(32'h800, $urandom_range(1, 10), 1'b0);
        send_pkt(32'h800, $urandom_range(1, 10), 1'b0);
        check("armed_addr_idx3", o_rx_base_addr, 32'h1000_C000);
        send_pkt($urandom, $urandom_range(1, 10), 1'b0);
        check_state("full");
        check("full_occupancy_const", o_occupancy, 4);
        send_pkt($urandom, $urandom_range(1, 10), 1'b0);
        check("ovf_flag_const", o_overflow, 1);
        check("ovf_drop_const", o_drop_cnt, 1);
        do_release();
        check("wrap_addr", o_rx_base_addr, 32'h1000_0000);

        do_release();
        send_pkt($urandom, $urandom_range(3, 10), 1'b1);
        check("concur_occupancy", o_occupancy, 2);
        check("concur_wr_idx", o_wr_idx, 1);
        check("concur_rd_idx", o_rd_idx, 3);
        do_release();
        do_release();
        do_release();
        check_state("empty_release");

        i_buf_stride = 32'h0000_4003;
        repeat (4) send_pkt($urandom, $urandom_range(1, 10), 1'b0);
        repeat (4) do_release();
        check("stride_mask_addr", o_rx_base_addr, 32'h1000_4000);
        check_state("stride");

        @(posedge clk); #1;
        i_rx_interrupt = 1'b1; i_rx_total_packet = $urandom;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midpkt");
        i_rx_interrupt = 1'b0; i_enable = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_state("post_reset");
        enable_ring();

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op == 0) begin
                i_ring_base_addr = $urandom;
                i_buf_stride     = $urandom_range(0, 32'h0001_0000);
            end else if (op <= 3) begin
                do_release();
            end else begin
                send_pkt($urandom, $urandom_range(1, 10),
                         (m_occ > 0 && m_occ < NB && $urandom_range(0, 2) == 0));
            end
        end
        #1;
        check_state("random");
        repeat (NB) do_release();
        check("start_q_drained", start_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
